// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch stage feeding the decoder of the SIMD AES core. It owns
//   the program counter, reads a synchronous 1-cycle-latency instruction ROM,
//   buffers the returned words (tagged with their PC) in a small FIFO and
//   presents the head entry to the decoder. A redirect flushes everything,
//   including the word arriving that cycle, and restarts fetch at the target.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst_n          : synchronous active-low reset
//   imem_req       : ROM read strobe (data returns the following cycle)
//   imem_addr      : ROM read address, always the current pc
//   imem_rdata     : ROM data, valid the cycle after imem_req
//   redirect_valid : branch taken, flush and restart at redirect_pc
//   redirect_pc    : restart address
//   id_valid       : FIFO head is valid
//   id_ready       : decoder accepts the head this cycle
//   id_instr       : head instruction word (0 when empty)
//   id_pc          : PC of the head instruction (0 when empty)
//   id_opcode      : top 5 bits of id_instr
//
// Handshake: the head entry transfers on a rising edge where id_valid and
// id_ready are both high and redirect_valid is low. While id_valid is high
// and no transfer happens, id_instr/id_pc/id_opcode hold stable. id_valid
// does not depend on id_ready.

module fetch_queue #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter int                 DEPTH    = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [4:0]         id_opcode
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_q;
    logic               inflight;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];

    logic               pop;
    logic               capture;
    logic [CNT_W:0]     occupancy;

    assign pop     = id_valid && id_ready && !redirect_valid;
    assign capture = inflight && !redirect_valid;

    // Slots committed after this edge: stored words plus the word landing
    // now, minus the one leaving. pop implies count >= 1, so no underflow.
    assign occupancy = {1'b0, count}
                     + (CNT_W + 1)'(inflight)
                     - (CNT_W + 1)'(pop);

    assign imem_req  = rst_n && !redirect_valid
                     && (occupancy < (CNT_W + 1)'(DEPTH));
    assign imem_addr = pc;

    assign id_valid  = (count != '0);
    assign id_instr  = id_valid ? fifo_instr[rd_ptr] : '0;
    assign id_pc     = id_valid ? fifo_pc[rd_ptr]    : '0;
    assign id_opcode = id_instr[INSTR_W-1 -: 5];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            pc_q     <= '0;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            // Redirect beats pop and capture; the arriving word is dropped.
            pc       <= redirect_pc;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (imem_req) begin
                pc       <= pc + ADDR_W'(PC_STEP);
                pc_q     <= pc;
                inflight <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
            if (capture) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(capture) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: outputs are masked while count is zero.
    always_ff @(posedge clk) begin
        if (rst_n && capture) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= pc_q;
        end
    end

endmodule
